wavelet_filter_bank: RTL and testbench

- Parametrised successor to the fixed FIR wavelet bank.
- One shared delay line feeds NUM_FILTERS Haar-style band channels. Channel k spans BASE_NUM_ELEM·2^k taps.
- Instead of parallel FIRs, a single time-multiplexed accumulator walks every channel once per accepted sample. It emits one signed coefficient per channel on a valid strobe, with a per-channel threshold LED.
- Sits between the sample source (valid/ready) and the display/host readout.

---
 rtl/wavelet_pkg.sv | 20 ++
 rtl/wavelet_tap_line.sv | 27 ++
 rtl/wavelet_filter_bank.sv | 119 +++++++++++
 tb/tb_wavelet_filter_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pkg.sv
// Shared types and sizing helpers for the time-multiplexed Haar wavelet bank.
// Channel k spans base<<k taps; the widest channel sets the delay-line depth.
package wavelet_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    function automatic int tap_count(input int base, input int k);
        return base << k;
    endfunction

    function automatic int total_taps(input int base, input int nf);
        return base << (nf - 1);
    endfunction

    // Half the taps add, half subtract, so the magnitude grows by TOTAL_TAPS/2 plus a sign bit.
    function automatic int acc_width(input int bits, input int base, input int nf);
        return bits + $clog2(total_taps(base, nf) / 2) + 1;
    endfunction

endpackage

// File: rtl/wavelet_tap_line.sv
// Sample delay line: tap[0] newest, tap[DEPTH-1] oldest, shifts only when en is high.
// A single indexed read port feeds the shared accumulator.
module wavelet_tap_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (rst)
            taps <= '0;
        else if (en)
            taps <= {taps[DEPTH-2:0], din};
    end

    assign dout = taps[idx];

endmodule

// File: rtl/wavelet_filter_bank.sv
// Haar-style filter bank: one accumulator walks each channel's taps per accepted
// sample and strobes out one signed coefficient per channel, with threshold LEDs.
module wavelet_filter_bank
    import wavelet_pkg::*;
#(
    parameter int BITS_PER_ELEM = 8,
    parameter int BASE_NUM_ELEM = 4,
    parameter int NUM_FILTERS   = 4,
    parameter int THRESHOLD     = 512,
    localparam int TOTAL_TAPS   = total_taps(BASE_NUM_ELEM, NUM_FILTERS),
    localparam int ACC_W        = acc_width(BITS_PER_ELEM, BASE_NUM_ELEM, NUM_FILTERS),
    localparam int CH_W         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BITS_PER_ELEM-1:0] i_value,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic signed [ACC_W-1:0]  o_coeff,
    output logic [CH_W-1:0]          o_chan,
    output logic                     o_valid,
    output logic                     o_drop,
    output logic [NUM_FILTERS-1:0]   o_led
);

    localparam int TAP_W = $clog2(TOTAL_TAPS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_FILTERS - 1);
    localparam logic [31:0] THR = 32'(THRESHOLD);

    state_t                    state, state_nxt;
    logic [CH_W-1:0]           chan;
    logic [TAP_W-1:0]          tap_idx;
    logic [TAP_W:0]            len;
    logic signed [ACC_W-1:0]   acc, tap_ext;
    logic [BITS_PER_ELEM-1:0]  tap_val;
    logic [ACC_W-1:0]          mag;
    logic                      accept, last_tap, first_half, hit;

    assign o_ready    = (state == IDLE);
    assign accept     = o_ready && i_valid;
    assign len        = (TAP_W+1)'(tap_count(BASE_NUM_ELEM, int'(chan)));
    assign last_tap   = ({1'b0, tap_idx} == len - 1'b1);
    assign first_half = ({1'b0, tap_idx} < (len >> 1));
    assign tap_ext    = ACC_W'(tap_val);
    // Most-negative acc is unreachable, so plain negation is a safe magnitude.
    assign mag        = acc[ACC_W-1] ? -acc : acc;
    assign hit        = (32'(mag) >= THR);

    wavelet_tap_line #(
        .WIDTH (BITS_PER_ELEM),
        .DEPTH (TOTAL_TAPS)
    ) u_taps (
        .clk  (clk),
        .rst  (rst),
        .en   (accept),
        .din  (i_value),
        .idx  (tap_idx),
        .dout (tap_val)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = ACCUM;
            ACCUM:   if (last_tap) state_nxt = EMIT;
            EMIT:    state_nxt = (chan == LAST_CH) ? IDLE : ACCUM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chan    <= '0;
            tap_idx <= '0;
            acc     <= '0;
            o_valid <= 1'b0;
            o_drop  <= 1'b0;
            o_coeff <= '0;
            o_chan  <= '0;
            o_led   <= '0;
        end else begin
            o_valid <= 1'b0;
            o_drop  <= i_valid && !o_ready;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        chan    <= '0;
                        tap_idx <= '0;
                        acc     <= '0;
                    end
                end
                ACCUM: begin
                    acc     <= first_half ? acc + tap_ext : acc - tap_ext;
                    tap_idx <= tap_idx + 1'b1;
                end
                EMIT: begin
                    o_valid     <= 1'b1;
                    o_coeff     <= acc;
                    o_chan      <= chan;
                    o_led[chan] <= hit;
                    if (chan != LAST_CH) begin
                        chan    <= chan + 1'b1;
                        tap_idx <= '0;
                        acc     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wavelet_filter_bank.sv
// Self-checking bench: per-cycle scoreboard against an arithmetic model of the
// Haar sums, plus table rows and hand sequences for reset, drops and step inputs.
module tb_wavelet_filter_bank;

    localparam int NF   = 4;
    localparam int BASE = 4;
    localparam int TT   = BASE << (NF - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic [7:0]        i_value = '0;
    logic              o_ready, o_valid, o_drop;
    logic signed [12:0] o_coeff;
    logic [1:0]        o_chan;
    logic [3:0]        o_led;

    wavelet_filter_bank dut (
        .clk     (clk),
        .rst     (rst),
        .i_value (i_value),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_coeff (o_coeff),
        .o_chan  (o_chan),
        .o_valid (o_valid),
        .o_drop  (o_drop),
        .o_led   (o_led)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         hist [TT];
    int         exp_c [NF];
    int         got_c [NF];
    logic [3:0] m_led = '0;
    bit         m_busy = 1'b0;
    int         start_cyc = 0;
    int         cyc = 0;
    int         drops_seen = 0;
    int         accepts_seen = 0;

    typedef struct {
        bit         do_rst;
        int         value;
        int         reps;
        int         c [NF];
        logic [3:0] led;
    } row_t;

    row_t rows [5];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge (relative to the accept edge) at which channel k's strobe is visible.
    function automatic int emit_edge(input int k);
        int e = 0;
        for (int j = 0; j <= k; j++) e += (BASE << j) + 1;
        return e;
    endfunction

    function automatic int model_coeff(input int k);
        int len = BASE << k;
        int s = 0;
        for (int i = 0; i < len; i++) s += (i < len / 2) ? hist[i] : -hist[i];
        return s;
    endfunction

    task automatic tick();
        bit acc_now, exp_drop, exp_v;
        int rel, ek, v_pre, mag;
        chk("ready", int'(o_ready), int'(!m_busy));
        acc_now  = i_valid && !rst && !m_busy;
        exp_drop = i_valid && !rst && m_busy;
        v_pre    = int'(i_value);
        if (acc_now) accepts_seen++;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_led  = '0;
            for (int i = 0; i < TT; i++) hist[i] = 0;
        end else if (acc_now) begin
            for (int i = TT - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = v_pre;
            for (int k = 0; k < NF; k++) exp_c[k] = model_coeff(k);
            m_busy    = 1'b1;
            start_cyc = cyc;
        end
        #1;
        exp_v = 1'b0;
        ek    = 0;
        if (m_busy) begin
            rel = cyc - start_cyc;
            for (int k = 0; k < NF; k++)
                if (rel == emit_edge(k)) begin
                    exp_v = 1'b1;
                    ek    = k;
                end
        end
        chk("valid", int'(o_valid), int'(exp_v));
        if (o_valid) got_c[o_chan] = int'(o_coeff);
        if (exp_v) begin
            chk($sformatf("chan ch%0d", ek), int'(o_chan), ek);
            chk($sformatf("coeff ch%0d", ek), int'(o_coeff), exp_c[ek]);
            mag = (exp_c[ek] < 0) ? -exp_c[ek] : exp_c[ek];
            m_led[ek] = (mag >= 512);
            if (ek == NF - 1) m_busy = 1'b0;
        end
        chk("drop", int'(o_drop), int'(exp_drop));
        if (o_drop) drops_seen++;
        chk("led", int'(o_led), int'(m_led));
    endtask

    task automatic wait_done();
        i_valid = 1'b0;
        for (int i = 0; i < 80 && m_busy; i++) tick();
        if (m_busy) chk("done timeout", 1, 0);
    endtask

    // Reset with a simultaneous offered sample: reset must win.
    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b1;
        i_value = 8'd99;
        tick();
        rst = 1'b0;
        i_valid = 1'b0;
        chk("rst ready", int'(o_ready), 1);
        chk("rst valid", int'(o_valid), 0);
        chk("rst drop", int'(o_drop), 0);
        chk("rst coeff", int'(o_coeff), 0);
        chk("rst chan", int'(o_chan), 0);
        chk("rst led", int'(o_led), 0);
    endtask

    task automatic send(input int v);
        for (int k = 0; k < NF; k++) got_c[k] = -99999;
        i_valid = 1'b1;
        i_value = 8'(v);
        tick();
        wait_done();
    endtask

    task automatic set_row(input int r, input bit rs, input int v, input int n,
                           input int c0, input int c1, input int c2, input int c3,
                           input logic [3:0] led);
        rows[r].do_rst = rs;
        rows[r].value  = v;
        rows[r].reps   = n;
        rows[r].c[0]   = c0;
        rows[r].c[1]   = c1;
        rows[r].c[2]   = c2;
        rows[r].c[3]   = c3;
        rows[r].led    = led;
    endtask

    task automatic apply_row(input int r);
        if (rows[r].do_rst) do_reset();
        for (int n = 0; n < rows[r].reps; n++) send(rows[r].value);
        for (int k = 0; k < NF; k++)
            chk($sformatf("row%0d ch%0d", r, k), got_c[k], rows[r].c[k]);
        chk($sformatf("row%0d led", r), int'(o_led), int'(rows[r].led));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < TT; i++) hist[i] = 0;
        set_row(0, 1'b1, 200, 1,   200,  200,  200,  200, 4'b0000);
        set_row(1, 1'b0,   0, 3,  -200,  200,  200,  200, 4'b0000);
        set_row(2, 1'b1, 100, 32,    0,    0,    0,    0, 4'b0000);
        set_row(3, 1'b1, 255, 16,    0,    0,    0, 4080, 4'b1000);
        set_row(4, 1'b0,  50, 1,    50,   50,   50,   50, 4'b0000);

        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 4; r++) apply_row(r);

        // Reset during channel 1 accumulation (LED 3 is lit from the step row).
        i_valid = 1'b1;
        i_value = 8'd7;
        tick();
        i_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst ready", int'(o_ready), 1);
        chk("midrst valid", int'(o_valid), 0);
        chk("midrst led", int'(o_led), 0);
        repeat (70) tick();
        apply_row(4);

        // Continuous offer: one accept per 65 cycles, drops on the rest.
        drops_seen = 0;
        accepts_seen = 0;
        i_valid = 1'b1;
        for (int i = 0; i < 130; i++) begin
            i_value = 8'($urandom_range(0, 255));
            tick();
        end
        wait_done();
        chk("burst accepts", accepts_seen, 2);
        chk("burst drops", drops_seen, 128);

        // Random traffic against the model, biased toward large values.
        for (int i = 0; i < 1500; i++) begin
            i_valid = ($urandom_range(0, 2) == 0);
            i_value = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(200, 255));
            tick();
        end
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
